// File: rtl/calc_entry_ctrl_if.sv
// ALU request/acknowledge channel between the entry sequencer and the shared ALU.
// The sequencer is the master: it raises alu_req with a stable op/a/b and waits for
// the single-cycle alu_ack strobe that carries the result and error flag.
interface calc_entry_ctrl_if #(
    parameter int W = 16
);
    logic         alu_req;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_ack;
    logic [W-1:0] alu_res;
    logic         alu_err;

    modport master (
        output alu_req, alu_op, alu_a, alu_b,
        input  alu_ack, alu_res, alu_err
    );

    modport slave (
        input  alu_req, alu_op, alu_a, alu_b,
        output alu_ack, alu_res, alu_err
    );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Keypad/function-key sequencer for the calculator datapath.
// Keys are synchronised, rising-edge detected, and accepted only when exactly one new
// edge appears in a cycle. Digits build operand A or B, operator keys launch the ALU
// through a req/ack handshake (with chaining), and the displayed value is presented with
// a one-cycle update strobe.
module calc_entry_ctrl #(
    parameter int W       = 16,
    parameter int MAX_DIG = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             swp,
    input  logic [7:0]              swd,
    calc_entry_ctrl_if.master       alu,
    output logic [W-1:0]            disp_val,
    output logic                    disp_upd,
    output logic [7:0]              led
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Function-key bits that mean something: ADD, SUB, MUL, DIV and EQ.
    localparam logic [7:0] SWD_KEYS = 8'b1111_0001;

    typedef enum logic [2:0] {
        ST_ENT_A = 3'd0,
        ST_OP    = 3'd1,
        ST_ENT_B = 3'd2,
        ST_EXEC  = 3'd3,
        ST_RES   = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    // Input synchroniser and previous-sample registers for edge detection.
    logic [11:0] swp_q, swp_qq;
    logic [7:0]  swd_q, swd_qq;

    // Operand and sequencing state.
    state_e        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [3:0]    cnt;
    alu_op_e       pend_op;
    alu_op_e       next_op;
    logic          next_op_vld;
    logic          launch;
    logic [TW-1:0] timer;

    // Decoded key for this cycle.
    logic [11:0] swp_e;
    logic [7:0]  swd_e;
    logic [19:0] key_vec;
    logic        key_valid;
    logic        is_digit;
    logic [3:0]  digit_val;
    logic        is_clr;
    logic        is_bksp;
    logic        is_op;
    logic        is_eq;
    alu_op_e     key_op;

    // Append one decimal digit; the product wraps to W bits by construction.
    function automatic logic [W-1:0] push_digit(input logic [W-1:0] v, input logic [3:0] d);
        return (v << 3) + (v << 1) + W'(d);
    endfunction

    // Register raw switches once, then keep the previous sample for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge value of its neighbours, regardless of statement order.
        if (rst) begin
            swp_q  <= '0;
            swp_qq <= '0;
            swd_q  <= '0;
            swd_qq <= '0;
        end else begin
            swp_q  <= swp;
            swp_qq <= swp_q;
            swd_q  <= swd;
            swd_qq <= swd_q;
        end
    end

    assign swp_e     = swp_q & ~swp_qq;
    assign swd_e     = swd_q & ~swd_qq & SWD_KEYS;
    assign key_vec   = {swp_e, swd_e};
    assign key_valid = (key_vec != '0) && ((key_vec & (key_vec - 20'd1)) == '0);

    // Decode the single accepted key edge into its class and value.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        is_digit  = 1'b0;
        digit_val = 4'd0;
        is_clr    = 1'b0;
        is_bksp   = 1'b0;
        is_op     = 1'b0;
        is_eq     = 1'b0;
        key_op    = OP_ADD;
        if (key_valid) begin
            for (int i = 3; i < 12; i++) begin
                if (swp_e[i]) begin
                    is_digit  = 1'b1;
                    digit_val = 4'(i - 2);
                end
            end
            if (swp_e[1]) begin
                is_digit  = 1'b1;
                digit_val = 4'd0;
            end
            is_clr  = swp_e[2];
            is_bksp = swp_e[0];
            is_eq   = swd_e[0];
            is_op   = |swd_e[7:4];
            if (swd_e[6]) key_op = OP_SUB;
            if (swd_e[5]) key_op = OP_MUL;
            if (swd_e[4]) key_op = OP_DIV;
        end
    end

    // Main sequencer: operand entry, ALU handshake, result/error handling, display.
    always_ff @(posedge clk) begin
        if (rst || is_clr) begin
            state       <= ST_ENT_A;
            a_reg       <= '0;
            b_reg       <= '0;
            cnt         <= '0;
            pend_op     <= OP_ADD;
            next_op     <= OP_ADD;
            next_op_vld <= 1'b0;
            launch      <= 1'b0;
            timer       <= '0;
            alu.alu_req <= 1'b0;
            alu.alu_op  <= OP_ADD;
            alu.alu_a   <= '0;
            alu.alu_b   <= '0;
            disp_val    <= '0;
            // Clearing a non-zero display is a visible change; a hard reset is silent.
            disp_upd    <= !rst && (disp_val != '0);
        end else begin
            disp_upd <= 1'b0;
            case (state)
                ST_ENT_A: begin
                    if (is_digit) begin
                        if (cnt < 4'(MAX_DIG)) begin
                            a_reg    <= push_digit(a_reg, digit_val);
                            disp_val <= push_digit(a_reg, digit_val);
                            cnt      <= cnt + 4'd1;
                            disp_upd <= 1'b1;
                        end
                    end else if (is_bksp) begin
                        if (cnt != '0) begin
                            a_reg    <= a_reg / W'(10);
                            disp_val <= a_reg / W'(10);
                            cnt      <= cnt - 4'd1;
                            disp_upd <= 1'b1;
                        end
                    end else if (is_op) begin
                        pend_op <= key_op;
                        cnt     <= '0;
                        state   <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (is_op) begin
                        pend_op <= key_op;
                    end else if (is_digit) begin
                        b_reg    <= W'(digit_val);
                        disp_val <= W'(digit_val);
                        disp_upd <= 1'b1;
                        cnt      <= 4'd1;
                        state    <= ST_ENT_B;
                    end
                end
                ST_ENT_B: begin
                    if (is_digit) begin
                        if (cnt < 4'(MAX_DIG)) begin
                            b_reg    <= push_digit(b_reg, digit_val);
                            disp_val <= push_digit(b_reg, digit_val);
                            cnt      <= cnt + 4'd1;
                            disp_upd <= 1'b1;
                        end
                    end else if (is_bksp) begin
                        if (cnt != '0) begin
                            b_reg    <= b_reg / W'(10);
                            disp_val <= b_reg / W'(10);
                            cnt      <= cnt - 4'd1;
                            disp_upd <= 1'b1;
                        end
                    end else if (is_op || is_eq) begin
                        alu.alu_a   <= a_reg;
                        alu.alu_b   <= b_reg;
                        alu.alu_op  <= pend_op;
                        next_op     <= key_op;
                        next_op_vld <= is_op;
                        launch      <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (launch) begin
                        // Operands settled last cycle; raise the request now.
                        launch      <= 1'b0;
                        alu.alu_req <= 1'b1;
                        timer       <= '0;
                    end else if (alu.alu_req) begin
                        if (alu.alu_ack) begin
                            alu.alu_req <= 1'b0;
                            if (alu.alu_err) begin
                                disp_val <= '0;
                                disp_upd <= (disp_val != '0);
                                state    <= ST_ERR;
                            end else begin
                                a_reg    <= alu.alu_res;
                                disp_val <= alu.alu_res;
                                disp_upd <= 1'b1;
                                if (next_op_vld) begin
                                    pend_op <= next_op;
                                    state   <= ST_OP;
                                end else begin
                                    state   <= ST_RES;
                                end
                            end
                        end else if (timer == TW'(TIMEOUT - 1)) begin
                            alu.alu_req <= 1'b0;
                            disp_val    <= '0;
                            disp_upd    <= (disp_val != '0);
                            state       <= ST_ERR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_RES: begin
                    if (is_op) begin
                        pend_op <= key_op;
                        state   <= ST_OP;
                    end else if (is_digit) begin
                        a_reg    <= W'(digit_val);
                        disp_val <= W'(digit_val);
                        disp_upd <= 1'b1;
                        cnt      <= 4'd1;
                        state    <= ST_ENT_A;
                    end
                end
                ST_ERR: begin
                    // Parked until CLR; the display is already forced to zero.
                end
                default: begin
                    state <= ST_ENT_A;
                end
            endcase
        end
    end

    // Status LEDs come straight from registered state.
    assign led = {cnt, (state == ST_ERR), state};

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed testbench for calc_entry_ctrl: drives keypad/function-key pulses, models the
// ALU with a fixed 3-cycle acknowledge (plus error / silent / late variants), and checks
// display, LEDs and ALU requests against hand-computed values.
module tb_calc_entry_ctrl;

    localparam logic [11:0] K_CLR  = 12'h004;
    localparam logic [11:0] K_BKSP = 12'h001;
    localparam logic [7:0]  K_ADD  = 8'h80;
    localparam logic [7:0]  K_SUB  = 8'h40;
    localparam logic [7:0]  K_DIV  = 8'h10;
    localparam logic [7:0]  K_EQ   = 8'h01;

    logic        clk;
    logic        rst;
    logic [11:0] swp;
    logic [7:0]  swd;
    logic [15:0] disp_val;
    logic        disp_upd;
    logic [7:0]  led;

    calc_entry_ctrl_if #(.W(16)) alu_if ();

    calc_entry_ctrl #(.W(16), .MAX_DIG(4), .TIMEOUT(255)) dut (
        .clk      (clk),
        .rst      (rst),
        .swp      (swp),
        .swd      (swd),
        .alu      (alu_if),
        .disp_val (disp_val),
        .disp_upd (disp_upd),
        .led      (led)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int upd_count    = 0;
    int alu_mode     = 0;  // 0 normal, 1 error, 2 never ack, 3 late ack
    int req_n        = 0;
    logic       req_prev = 1'b0;
    logic [1:0]  log_op [8];
    logic [15:0] log_a  [8];
    logic [15:0] log_b  [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count display update pulses.
    always @(negedge clk) begin
        if (disp_upd === 1'b1) upd_count++;
    end

    // Log every rising ALU request.
    always @(negedge clk) begin
        if (alu_if.alu_req === 1'b1 && req_prev !== 1'b1 && req_n < 8) begin
            log_op[req_n] = alu_if.alu_op;
            log_a[req_n]  = alu_if.alu_a;
            log_b[req_n]  = alu_if.alu_b;
            req_n++;
        end
        req_prev = alu_if.alu_req;
    end

    function automatic logic [15:0] alu_calc(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return (b == 16'd0) ? 16'd0 : a / b;
        endcase
    endfunction

    // ALU model: acknowledge 3 cycles after seeing the request.
    initial begin
        alu_if.alu_ack = 1'b0;
        alu_if.alu_res = '0;
        alu_if.alu_err = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_if.alu_req === 1'b1) begin
                case (alu_mode)
                    0, 1: begin
                        repeat (2) @(negedge clk);
                        alu_if.alu_res = alu_calc(alu_if.alu_op, alu_if.alu_a, alu_if.alu_b);
                        alu_if.alu_err = (alu_mode == 1);
                        alu_if.alu_ack = 1'b1;
                        @(negedge clk);
                        alu_if.alu_ack = 1'b0;
                        alu_if.alu_err = 1'b0;
                    end
                    2: begin
                        while (alu_if.alu_req === 1'b1) @(negedge clk);
                    end
                    default: begin
                        repeat (20) @(negedge clk);
                        alu_if.alu_res = 16'd10;
                        alu_if.alu_ack = 1'b1;
                        @(negedge clk);
                        alu_if.alu_ack = 1'b0;
                    end
                endcase
            end
        end
    end

    task automatic press(input logic [11:0] p, input logic [7:0] d);
        @(negedge clk);
        swp = p;
        swd = d;
        @(negedge clk);
        swp = '0;
        swd = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic dig(input int n);
        logic [11:0] p;
        p = '0;
        if (n == 0) p[1] = 1'b1;
        else        p[n + 2] = 1'b1;
        press(p, 8'h00);
    endtask

    task automatic wait_exec(input string tag);
        int n;
        n = 0;
        while (led[2:0] == 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 100), 1);
    endtask

    initial begin
        int u0;
        int n;
        swp = '0;
        swd = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_disp", disp_val, 0);
        check("rst_upd", disp_upd, 0);
        check("rst_led", led, 0);
        check("rst_req", alu_if.alu_req, 0);

        // 1: 23 + 456 - 234 with chained operator
        dig(2);
        dig(3);
        check("t1_a23", disp_val, 23);
        press('0, K_ADD);
        check("t1_state_op", led[2:0], 1);
        dig(4);
        dig(5);
        dig(6);
        check("t1_b456", disp_val, 456);
        @(negedge clk);
        swd = K_SUB;
        @(posedge clk); #1;
        check("t1_req_lat0", alu_if.alu_req, 0);
        @(negedge clk);
        swd = '0;
        @(posedge clk); #1;
        check("t1_req_lat1", alu_if.alu_req, 0);
        @(posedge clk); #1;
        check("t1_req_lat2", alu_if.alu_req, 1);
        wait_exec("t1_exec0");
        check("t1_req_n1", req_n, 1);
        check("t1_op0", log_op[0], 0);
        check("t1_a0", log_a[0], 23);
        check("t1_b0", log_b[0], 456);
        check("t1_disp479", disp_val, 479);
        check("t1_chain_op", led[2:0], 1);
        dig(2);
        dig(3);
        dig(4);
        press('0, K_EQ);
        wait_exec("t1_exec1");
        check("t1_req_n2", req_n, 2);
        check("t1_op1", log_op[1], 1);
        check("t1_a1", log_a[1], 479);
        check("t1_b1", log_b[1], 234);
        check("t1_disp245", disp_val, 245);
        check("t1_state_res", led[2:0], 4);

        // 2: digit latency, MAX_DIG limit, backspace
        @(negedge clk);
        swp = 12'h008;
        @(posedge clk); #1;
        check("t2_upd_lat0", disp_upd, 0);
        @(negedge clk);
        swp = '0;
        @(posedge clk); #1;
        check("t2_upd_lat1", disp_upd, 1);
        check("t2_disp1", disp_val, 1);
        dig(2);
        dig(3);
        dig(4);
        dig(5);
        check("t2_disp1234", disp_val, 1234);
        check("t2_cnt4", led[7:4], 4);
        check("t2_state", led[2:0], 0);
        press(K_BKSP, 8'h00);
        check("t2_bksp", disp_val, 123);
        check("t2_cnt3", led[7:4], 3);
        press(K_CLR, 8'h00);
        check("t2_clr", disp_val, 0);

        // 3: simultaneous edges ignored; held key registers once
        u0 = upd_count;
        press(12'h800, K_ADD);
        check("t3_no_upd", upd_count, u0);
        check("t3_state", led[2:0], 0);
        check("t3_disp", disp_val, 0);
        @(negedge clk);
        swp = 12'h200;
        repeat (50) @(negedge clk);
        swp = '0;
        repeat (2) @(negedge clk);
        check("t3_held_disp", disp_val, 7);
        check("t3_held_upd", upd_count, u0 + 1);

        // 4: divide by zero reported as error
        press(K_CLR, 8'h00);
        alu_mode = 1;
        dig(9);
        press('0, K_DIV);
        dig(0);
        press('0, K_EQ);
        wait_exec("t4_exec");
        check("t4_state_err", led[2:0], 5);
        check("t4_led_err", led[3], 1);
        check("t4_disp0", disp_val, 0);
        dig(5);
        check("t4_ign_state", led[2:0], 5);
        check("t4_ign_disp", disp_val, 0);
        press(K_CLR, 8'h00);
        check("t4_clr_led", led, 0);
        check("t4_clr_disp", disp_val, 0);

        // 5: no acknowledge -> ERR exactly TIMEOUT cycles after request
        alu_mode = 2;
        dig(9);
        press('0, K_ADD);
        dig(1);
        @(negedge clk);
        swd = K_EQ;
        @(negedge clk);
        swd = '0;
        n = 0;
        while (alu_if.alu_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_req_seen", alu_if.alu_req, 1);
        n = 0;
        while (led[2:0] != 3'd5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout", n, 255);
        check("t5_req_drop", alu_if.alu_req, 0);
        press(K_CLR, 8'h00);

        // 5b: CLR during EXEC, late acknowledge discarded
        alu_mode = 3;
        dig(9);
        press('0, K_ADD);
        dig(1);
        press('0, K_EQ);
        check("t5b_exec", led[2:0], 3);
        check("t5b_req", alu_if.alu_req, 1);
        press(K_CLR, 8'h00);
        check("t5b_clr_led", led, 0);
        check("t5b_clr_req", alu_if.alu_req, 0);
        u0 = upd_count;
        repeat (30) @(negedge clk);
        check("t5b_late_led", led, 0);
        check("t5b_late_disp", disp_val, 0);
        check("t5b_late_upd", upd_count, u0);

        // 6: synchronous reset mid-entry
        alu_mode = 0;
        dig(5);
        dig(7);
        check("t6_a57", disp_val, 57);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_disp", disp_val, 0);
        check("t6_upd", disp_upd, 0);
        check("t6_led", led, 0);
        check("t6_req", alu_if.alu_req, 0);
        check("t6_op", alu_if.alu_op, 0);
        check("t6_a", alu_if.alu_a, 0);
        check("t6_b", alu_if.alu_b, 0);
        @(negedge clk);
        rst = 1'b0;
        dig(3);
        check("t6_after", disp_val, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
